instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the main control decoder: accepts instruction fields (class, registers, funct3, immediate) and emits the packed 32-bit instruction word.
- Supports exactly the classes the core decodes: R, I-ALU, LOAD, S, B, JAL, LUI.
- Output carries an auto-incrementing word address and feeds the instruction-memory loader/self-test program generator.
- Valid/ready on both sides, one registered output stage, sticky error flags.

Parameters:
- ADDR_WIDTH, 32, width of out_addr.
- BASE_ADDR, 0, out_addr value after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept
- in_class  in  3  0=R 1=I-ALU 2=LOAD 3=S 4=B 5=JAL 6=LUI 7=reserved
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  funct7 bit 5 (SUB/SRA/SRAI)
- in_imm  in  32  byte-offset immediate; for LUI the full upper value
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_WIDTH  byte address of out_instr
- err_illegal  out  1  sticky: class 7 received
- err_range  out  1  sticky: immediate out of range or misaligned

Behaviour:
- Reset:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_illegal=0, err_range=0.
  - Reset mid-transfer discards any held word.
- Input handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
- Latency: an accepted legal input appears on out_instr with out_valid=1 on the next cycle.
- Output holding:
  - out_instr and out_addr stay stable while out_valid && !out_ready.
  - Simultaneous output handshake and new accept loads the new word the same edge, with no bubble.
- Address:
  - On each output handshake (out_valid && out_ready), the address register advances by 4 and wraps modulo 2^ADDR_WIDTH.
  - out_addr always shows the address of the currently held or next word.
- Encodings (opcode in bits [6:0]):
  - R: {0,funct7b5,00000, rs2, rs1, f3, rd, 0110011}
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}. When f3 is 001 or 101, bits [31:25] are forced to {0,funct7b5,00000} and bits [24:20]=imm[4:0].
  - LOAD: as I-ALU with opcode 0000011, no shift override.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
  - LUI: {imm[31:12], rd, 0110111}
- Range rules (violation drops the word):
  - I-ALU non-shift, LOAD, S: imm[31:11] all equal.
  - I shift: imm[31:5]==0.
  - B: imm[31:12] all equal, imm[0]==0.
  - JAL: imm[31:20] all equal, imm[0]==0.
  - LUI: imm[11:0]==0.
- Error handling:
  - Illegal class or range violation: input is still accepted (consumed), no output word is produced, and the address does not advance.
  - The corresponding err_* flag sets the next cycle and holds until rst.
  - If a dropped input coincides with an output handshake, out_valid falls to 0.
- Unused fields per class are ignored; R/S/B ignore in_rd; LUI/JAL ignore rs1/rs2/funct3.

Decomposition:
- Shared package riscv_pkg:
  - opcode localparams OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_LUI, matching the decoder's constants.
  - enum instr_class_t (3-bit).
- One combinational sub-module, instr_field_pack: class + fields → {instr[31:0], illegal, range_err}.
- instr_encoder holds the handshake register, address counter and sticky flags.

Test Plan:
- Reset, then R class rd=3 rs1=1 rs2=2 f3=0 f7b5=0 → out_instr=0x002081B3 at addr 0. Same with f7b5=1 → 0x402081B3 at addr 4.
- I-ALU rd=1 rs1=0 imm=5 → 0x00500093. S rs1=1 rs2=2 f3=2 imm=8 → 0x0020A423. LUI rd=5 imm=0x12345000 → 0x123452B7.
- B rs1=1 rs2=2 f3=0 imm=-4 → 0xFE208EE3. JAL imm=3 → err_range=1, no out_valid, out_addr unchanged.
- class=7 → err_illegal=1 sticky until rst; the following legal word still encodes at the unchanged address.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_instr/out_addr stable. Release → back-to-back words with no bubble, address +4 each.
- ADDR_WIDTH=4, BASE_ADDR=8: two handshakes → out_addr 8, 12, then wraps to 0. rst asserted while holding a word → out_valid=0, out_addr=8 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and instruction class enum.
// Opcodes match the main control decoder.
package riscv_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [2:0] {
    CL_R    = 3'd0,
    CL_I    = 3'd1,
    CL_LOAD = 3'd2,
    CL_S    = 3'd3,
    CL_B    = 3'd4,
    CL_JAL  = 3'd5,
    CL_LUI  = 3'd6,
    CL_RSVD = 3'd7
  } instr_class_t;

  // True when v is the sign extension of its low n bits.
  function automatic logic fits_signed(
    input logic [31:0] v,
    input int unsigned n
  );
    logic signed [31:0] hi;
    hi = $signed(v) >>> (n - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: class + fields -> instruction word.
// Ports: cls/rd/rs1/rs2/funct3/funct7b5/imm in; instr, illegal, range_err out.
module instr_field_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        illegal,
  output logic        range_err
);

  instr_class_t c;
  logic         shift;

  assign c     = instr_class_t'(cls);
  assign shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    instr     = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    unique case (c)
      CL_R: begin
        instr = {1'b0, funct7b5, 5'b0, rs2, rs1,
                 funct3, rd, OP_R};
      end
      CL_I: begin
        if (shift) begin
          instr = {1'b0, funct7b5, 5'b0, imm[4:0],
                   rs1, funct3, rd, OP_I};
          range_err = |imm[31:5];
        end else begin
          instr = {imm[11:0], rs1, funct3, rd, OP_I};
          range_err = !fits_signed(imm, 12);
        end
      end
      CL_LOAD: begin
        instr = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        range_err = !fits_signed(imm, 12);
      end
      CL_S: begin
        instr = {imm[11:5], rs2, rs1, funct3,
                 imm[4:0], OP_S};
        range_err = !fits_signed(imm, 12);
      end
      CL_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                 imm[4:1], imm[11], OP_B};
        range_err = !fits_signed(imm, 13) || imm[0];
      end
      CL_JAL: begin
        instr = {imm[20], imm[10:1], imm[11],
                 imm[19:12], rd, OP_JAL};
        range_err = !fits_signed(imm, 21) || imm[0];
      end
      CL_LUI: begin
        instr = {imm[31:12], rd, OP_LUI};
        range_err = |imm[11:0];
      end
      CL_RSVD: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one registered output stage with address counter.
// Ports: in_* fields + valid/ready, out_instr/out_addr + valid/ready, sticky err_*.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [31:0]           in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_illegal,
  output logic                  err_range
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

  logic [31:0] word;
  logic        illegal;
  logic        range_err;
  logic        accept;
  logic        hs;
  logic        drop;

  instr_field_pack u_pack (
    .cls       (in_class),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .funct3    (in_funct3),
    .funct7b5  (in_funct7b5),
    .imm       (in_imm),
    .instr     (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign drop     = illegal || range_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_addr    <= BASE_ADDR;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      // Address names the next word, so it moves only when one leaves.
      if (hs) begin
        out_addr <= out_addr + STEP;
      end
      if (accept && !drop) begin
        out_valid <= 1'b1;
        out_instr <= word;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
      if (accept && illegal) begin
        err_illegal <= 1'b1;
      end
      if (accept && range_err) begin
        err_range <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder with a field-arithmetic reference model.
// Directed vectors, backpressure, random traffic, reset and address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst2;
  logic        in_valid;
  logic        in_valid2;
  logic        in_ready;
  logic        in_ready2;
  logic [2:0]  in_class;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_valid2;
  logic        out_ready;
  logic        out_ready2;
  logic [31:0] out_instr;
  logic [31:0] out_instr2;
  logic [31:0] out_addr;
  logic [3:0]  out_addr2;
  logic        err_illegal;
  logic        err_illegal2;
  logic        err_range;
  logic        err_range2;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic [31:0] maddr;
  logic        mill;
  logic        mrng;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .err_illegal (err_illegal),
    .err_range   (err_range)
  );

  instr_encoder #(
    .ADDR_WIDTH (4),
    .BASE_ADDR  (4'd8)
  ) dut2 (
    .clk         (clk),
    .rst         (rst2),
    .in_valid    (in_valid2),
    .in_ready    (in_ready2),
    .in_class    (in_class),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .in_imm      (in_imm),
    .out_valid   (out_valid2),
    .out_ready   (out_ready2),
    .out_instr   (out_instr2),
    .out_addr    (out_addr2),
    .err_illegal (err_illegal2),
    .err_range   (err_range2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: place each field by shift/mask arithmetic; legality by
  // signed numeric ranges.
  function automatic logic [31:0] ref_word(
    input int unsigned c,
    input logic [31:0] rd,
    input logic [31:0] rs1,
    input logic [31:0] rs2,
    input logic [31:0] f3,
    input logic [31:0] f7,
    input logic [31:0] u,
    output bit ok,
    output bit bad_cls
  );
    int s;
    logic [31:0] regs;
    s = u;
    ok = 1;
    bad_cls = 0;
    regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
    ref_word = 0;
    case (c)
      0: ref_word = (f7 << 30) | regs | (rd << 7) | 32'h33;
      1: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (u < 32);
          ref_word = (f7 << 30) | ((u & 31) << 20)
                   | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end else begin
          ok = (s >= -2048 && s <= 2047);
          ref_word = ((u & 32'hFFF) << 20) | (rs1 << 15)
                   | (f3 << 12) | (rd << 7) | 32'h13;
        end
      end
      2: begin
        ok = (s >= -2048 && s <= 2047);
        ref_word = ((u & 32'hFFF) << 20) | (rs1 << 15)
                 | (f3 << 12) | (rd << 7) | 32'h03;
      end
      3: begin
        ok = (s >= -2048 && s <= 2047);
        ref_word = (((u >> 5) & 32'h7F) << 25) | regs
                 | ((u & 31) << 7) | 32'h23;
      end
      4: begin
        ok = (s >= -4096 && s <= 4095) && (s % 2 == 0);
        ref_word = (((u >> 12) & 1) << 31)
                 | (((u >> 5) & 63) << 25) | regs
                 | (((u >> 1) & 15) << 8)
                 | (((u >> 11) & 1) << 7) | 32'h63;
      end
      5: begin
        ok = (s >= -1048576 && s <= 1048575) && (s % 2 == 0);
        ref_word = (((u >> 20) & 1) << 31)
                 | (((u >> 1) & 32'h3FF) << 21)
                 | (((u >> 11) & 1) << 20)
                 | (((u >> 12) & 32'hFF) << 12)
                 | (rd << 7) | 32'h6F;
      end
      6: begin
        ok = (u % 4096 == 0);
        ref_word = (u & 32'hFFFFF000) | (rd << 7) | 32'h37;
      end
      default: begin
        ok = 0;
        bad_cls = 1;
      end
    endcase
  endfunction

  // One cycle: check outputs, advance the model, cross the next posedge.
  task automatic tick();
    bit acc, hs, ok, bad;
    logic [31:0] w;
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0) chk("out_instr", out_instr, q[0]);
    chk("out_addr", out_addr, maddr);
    chk("in_ready", {31'b0, in_ready},
        {31'b0, (q.size() == 0) || out_ready});
    chk("err_illegal", {31'b0, err_illegal}, {31'b0, mill});
    chk("err_range", {31'b0, err_range}, {31'b0, mrng});
    hs  = (q.size() != 0) && out_ready;
    acc = in_valid && ((q.size() == 0) || out_ready);
    if (hs) begin
      void'(q.pop_front());
      maddr = maddr + 4;
    end
    if (acc) begin
      w = ref_word(in_class, in_rd, in_rs1, in_rs2, in_funct3,
                   in_funct7b5, in_imm, ok, bad);
      if (bad) mill = 1;
      else if (!ok) mrng = 1;
      else q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic set_f(input int c, input int rd, input int rs1,
                       input int rs2, input int f3, input int f7,
                       input logic [31:0] imm);
    in_class    = 3'(c);
    in_rd       = 5'(rd);
    in_rs1      = 5'(rs1);
    in_rs2      = 5'(rs2);
    in_funct3   = 3'(f3);
    in_funct7b5 = 1'(f7);
    in_imm      = imm;
  endtask

  task automatic send(input int c, input int rd, input int rs1,
                      input int rs2, input int f3, input int f7,
                      input logic [31:0] imm);
    set_f(c, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    maddr = 0;
    mill = 0;
    mrng = 0;
    #1;
    chk("rst_instr", out_instr, 32'h0);
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = $urandom_range(0, 63);
      1: v = -int'($urandom_range(0, 63));
      2: v = int'($urandom_range(0, 8191)) - 4096;
      3: v = $urandom & 32'hFFFFF000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b1;
    out_ready2 = 1'b1;
    set_f(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst2 = 1'b0;
    do_reset();
    tick();

    send(0, 3, 1, 2, 0, 0, 0);
    chk("r_add", out_instr, 32'h002081B3);
    chk("r_add_addr", out_addr, 32'd0);
    send(0, 3, 1, 2, 0, 1, 0);
    chk("r_sub", out_instr, 32'h402081B3);
    chk("r_sub_addr", out_addr, 32'd4);
    send(1, 1, 0, 0, 0, 0, 32'd5);
    chk("addi", out_instr, 32'h00500093);
    send(3, 0, 1, 2, 2, 0, 32'd8);
    chk("sw", out_instr, 32'h0020A423);
    send(6, 5, 0, 0, 0, 0, 32'h12345000);
    chk("lui", out_instr, 32'h123452B7);
    send(4, 0, 1, 2, 0, 0, 32'hFFFFFFFC);
    chk("beq", out_instr, 32'hFE208EE3);
    chk("beq_addr", out_addr, 32'd20);
    tick();

    send(5, 1, 0, 0, 0, 0, 32'd3);
    chk("jal_rng", {31'b0, err_range}, 32'd1);
    chk("jal_nov", {31'b0, out_valid}, 32'd0);
    chk("jal_addr", out_addr, 32'd24);
    send(7, 1, 1, 1, 0, 0, 0);
    chk("ill_set", {31'b0, err_illegal}, 32'd1);
    chk("ill_nov", {31'b0, out_valid}, 32'd0);
    send(2, 4, 2, 0, 2, 0, 32'hFFFFF800);
    chk("post_ill_v", {31'b0, out_valid}, 32'd1);
    chk("post_ill_a", out_addr, 32'd24);
    chk("ill_sticky", {31'b0, err_illegal}, 32'd1);

    out_ready = 1'b0;
    in_valid = 1'b1;
    set_f(1, 9, 8, 0, 5, 1, 32'd31);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    set_f(0, 10, 11, 12, 7, 0, 0);
    tick();
    set_f(4, 0, 3, 4, 1, 0, 32'd4094);
    tick();
    in_valid = 1'b0;
    chk("b2b_v", {31'b0, out_valid}, 32'd1);
    chk("b2b_addr", out_addr, 32'd36);
    tick();

    for (int i = 0; i < 600; i++) begin
      set_f($urandom_range(0, 15) == 0 ? 7 : $urandom_range(0, 6),
            $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), $urandom_range(0, 7),
            $urandom_range(0, 1), rand_imm());
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    out_ready = 1'b0;
    send(0, 1, 2, 3, 0, 0, 0);
    tick();
    do_reset();
    tick();
    out_ready = 1'b1;

    set_f(0, 3, 1, 2, 0, 0, 0);
    in_valid2 = 1'b1;
    out_ready2 = 1'b1;
    @(negedge clk);
    #1;
    chk("w_v0", {31'b0, out_valid2}, 32'd1);
    chk("w_a0", {28'b0, out_addr2}, 32'd8);
    chk("w_i0", out_instr2, 32'h002081B3);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    chk("w_a1", {28'b0, out_addr2}, 32'd12);
    @(negedge clk);
    #1;
    chk("w_wrap", {28'b0, out_addr2}, 32'd0);
    chk("w_v2", {31'b0, out_valid2}, 32'd0);
    in_valid2 = 1'b1;
    out_ready2 = 1'b0;
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    chk("w_hold", {31'b0, out_valid2}, 32'd1);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("w_rst_v", {31'b0, out_valid2}, 32'd0);
    chk("w_rst_a", {28'b0, out_addr2}, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
